rst_seq_xilusp: RTL and testbench
=================================

# rst_seq_xilusp

Board-level reset sequencer for the ZCU104 Earl Grey top, sitting directly upstream of `clkgen_xilusp`. It replaces the free-running power-on counter with a defined sequence:
- a power-on hold;
- wait for a stable MMCM lock;
- release reset.

It re-enters the sequence on a debounced push-button, a software reset request or loss of lock. Its `rst_no` drives `clkgen_xilusp.IO_RST_N`.

## Interface
Parameters:
- `PorCycles`, 1000: cycles reset is held after `rst_ni` is sampled high. Must be ≥ 3.
- `LockCycles`, 64: consecutive cycles `pll_locked_i` (synchronised) must be high before release. Must be ≥ 1.
- `DebounceCycles`, 16: consecutive cycles the synchronised button must differ from its stable value before the stable value flips. Must be ≥ 1.

Ports:
- `clk_i`  in  1  board clock (post-BUFG).
- `rst_ni`  in  1  reset, synchronous, active-low.
- `btn_rst_i`  in  1  asynchronous push-button, active-high.
- `pll_locked_i`  in  1  asynchronous MMCM lock indication.
- `sw_rst_req_i`  in  1  synchronous single-cycle software reset request.
- `rst_no`  out  1  registered system reset, active-low.
- `state_o`  out  2  current sequencer state, for debug.
- `rst_cause_o`  out  2  last reset cause: 00 POR, 01 LOCK_LOSS, 10 BUTTON, 11 SW.

## Operation
Input conditioning:
- `btn_rst_i` and `pll_locked_i` each pass through a 2-flop synchroniser; both flops reset to 0.
- Debouncer: a counter increments while the synchronised button differs from the stable value and clears when they are equal. When the count reaches `DebounceCycles-1` and a mismatch is still present, the stable value flips and the counter clears.
- The stable value resets to 0. A press event is its 0→1 transition, a 1-cycle pulse.

State machine, states POR=0, LOCK=1, RUN=2, one cycle counter:
- POR:
  - The counter increments every cycle.
  - At count `PorCycles-1` → LOCK, counter ← 0.
  - A press event → counter ← 0 and the state stays POR.
  - Lock level is ignored.
- LOCK:
  - The counter increments while lock is high and clears while lock is low.
  - At count `LockCycles-1` with lock high → RUN.
  - A press event → POR, counter ← 0.
- RUN:
  - Lock low → POR with cause LOCK_LOSS.
  - Otherwise a press event → POR with cause BUTTON.
  - Otherwise `sw_rst_req_i` → POR with cause SW.
  - Priority is LOCK_LOSS > BUTTON > SW.
- `sw_rst_req_i` is ignored outside RUN.
- Any transition into POR clears the counter.
- `rst_no` is registered and equals 1 iff the next state is RUN, so it rises on the same edge the state enters RUN. It falls on the same edge the state leaves RUN.
- The counter is `$clog2(max(PorCycles, LockCycles))` bits wide, with no wrap: it never exceeds its terminal value.

## Timing
Reset values while `rst_ni` is low:
- `rst_no`=0, `state_o`=0 (POR), `rst_cause_o`=00.
- Counter, synchronisers and debouncer cleared.

Latency and hold:
- With `pll_locked_i` held high, `rst_no` rises exactly `PorCycles+LockCycles` edges after the first edge sampling `rst_ni` high.
- Response from a `pll_locked_i` fall to a `rst_no` fall is 3 edges: 2 synchroniser edges plus 1 state edge.
- Response from a button press to a `rst_no` fall is 3 + `DebounceCycles` edges.
- `sw_rst_req_i` asserted in RUN: `rst_no` falls on the next edge.
- After any event in RUN, reset stays low for at least `PorCycles+LockCycles` cycles.

Boundary rules:
- `rst_ni` low mid-sequence overrides everything on the next edge.
- Lock dropping on the final LOCK cycle means no release; the counter clears.

## Configuration
- `RST_SEQ_CAUSE_EN` defined: a 2-bit cause register is implemented. It is loaded on each RUN→POR transition, holds its value otherwise, and drives `rst_cause_o`.
- `RST_SEQ_CAUSE_EN` undefined: there is no cause register, and `rst_cause_o` is tied to 2'b00.
- The sequencing behaviour is identical either way.

## Structure
- Package `rst_seq_pkg`: the `rst_state_e` enum (POR, LOCK, RUN) and the `rst_cause_e` enum (POR, LOCK_LOSS, BUTTON, SW).
- Sub-module `rst_seq_debounce`: synchroniser, debounce counter and press-pulse generation, parameterised by `DebounceCycles`.

## Test plan
- Power-up, `PorCycles`=1000, `LockCycles`=64, lock high → `rst_no` rises exactly 1064 edges after `rst_ni` release; `rst_cause_o`=00.
- Lock held low until cycle 2000, then high → `rst_no` rises 64+2 edges after the lock rise. Toggling lock low at cycle 30 of LOCK restarts the 64-cycle count.
- In RUN, button high for 10 cycles with `DebounceCycles`=16 → no reset. Button high for 20 cycles → `rst_no` falls 19 edges after the press; cause=10; `rst_no` returns high after 1064 cycles.
- In RUN, `sw_rst_req_i` and a lock drop arrive on the same cycle → cause=01 (LOCK_LOSS wins); `rst_no` falls at lock-sync latency.
- `sw_rst_req_i` pulsed during POR → ignored, release timing unchanged. The same pulse in RUN → `rst_no`=0 on the next edge, cause=11.
- `rst_ni` low at cycle 500 of POR → all outputs return to reset values on the next edge; the sequence restarts with the full 1064-edge count.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state and cause encodings for the board reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_LOCK = 2'd1,
        ST_RUN  = 2'd2
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'b00,
        CAUSE_LOCK_LOSS = 2'b01,
        CAUSE_BUTTON    = 2'b10,
        CAUSE_SW        = 2'b11
    } rst_cause_e;

endpackage

// File: rtl/rst_seq_debounce.sv
// rtl/rst_seq_debounce.sv - push-button synchroniser, debouncer and press-pulse generator
module rst_seq_debounce #(
    parameter int DebounceCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count consecutive mismatch cycles; flip the stable value once the mismatch has persisted
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchroniser plus debounce state; press pulse is registered alongside the flip
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/rst_seq_xilusp.sv
// rtl/rst_seq_xilusp.sv - POR hold / MMCM lock wait / release sequencer; RST_SEQ_CAUSE_EN adds the reset-cause register
module rst_seq_xilusp
    import rst_seq_pkg::*;
#(
    parameter int PorCycles      = 1000,
    parameter int LockCycles     = 64,
    parameter int DebounceCycles = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_rst_i,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    output logic       rst_no,
    output logic [1:0] state_o,
    output logic [1:0] rst_cause_o
);

    localparam int MaxCycles = (PorCycles > LockCycles) ? PorCycles : LockCycles;
    localparam int CntW      = $clog2(MaxCycles);
    localparam logic [CntW-1:0] PorLast  = CntW'(PorCycles - 1);
    localparam logic [CntW-1:0] LockLast = CntW'(LockCycles - 1);

    logic            lock_sync1_q, lock_sync2_q;
    logic            press;
    rst_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rst_q;

    rst_seq_debounce #(
        .DebounceCycles(DebounceCycles)
    ) u_debounce (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (btn_rst_i),
        .press_o(press)
    );

    // Bring the MMCM lock level into the board clock domain
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_sync1_q <= 1'b0;
            lock_sync2_q <= 1'b0;
        end else begin
            lock_sync1_q <= pll_locked_i;
            lock_sync2_q <= lock_sync1_q;
        end
    end

    // State, cycle counter and reset output; rst_no follows the next state so it moves with the state edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_POR;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= (state_d == ST_RUN);
        end
    end

    // Sequencing: hold in POR, require a run of lock cycles, then leave RUN on any reset event
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_POR: begin
                if (press) begin
                    cnt_d = '0;
                end else if (cnt_q == PorLast) begin
                    state_d = ST_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOCK: begin
                if (press) begin
                    state_d = ST_POR;
                    cnt_d   = '0;
                end else if (!lock_sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_sync2_q || press || sw_rst_req_i) begin
                    state_d = ST_POR;
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef RST_SEQ_CAUSE_EN
    rst_cause_e cause_q, cause_d;

    // Capture why RUN was left; priority lock loss, then button, then software
    always_comb begin
        cause_d = cause_q;
        if (state_q == ST_RUN && state_d == ST_POR) begin
            if (!lock_sync2_q) begin
                cause_d = CAUSE_LOCK_LOSS;
            end else if (press) begin
                cause_d = CAUSE_BUTTON;
            end else begin
                cause_d = CAUSE_SW;
            end
        end
    end

    // Cause register holds between RUN exits
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cause_q <= CAUSE_POR;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign rst_cause_o = cause_q;
`else
    assign rst_cause_o = 2'b00;
`endif

    // Debug and reset outputs straight from registers
    always_comb begin
        state_o = state_q;
        rst_no  = rst_q;
    end

endmodule

// File: tb/tb_rst_seq_xilusp.sv
// tb/tb_rst_seq_xilusp.sv - scoreboard bench for the board reset sequencer
module tb_rst_seq_xilusp;
    import rst_seq_pkg::*;

    localparam int PorCycles      = 1000;
    localparam int LockCycles     = 64;
    localparam int DebounceCycles = 16;
`ifdef RST_SEQ_CAUSE_EN
    localparam logic [1:0] CauseMask = 2'b11;
`else
    localparam logic [1:0] CauseMask = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       lock = 1'b0;
    logic       sw = 1'b0;
    logic       rst_out;
    logic [1:0] state;
    logic [1:0] cause;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_fall = 0;

    typedef struct {
        string      name;
        int         edges;
        logic [1:0] cause;
    } exp_t;

    exp_t sb[$];

    rst_seq_xilusp #(
        .PorCycles     (PorCycles),
        .LockCycles    (LockCycles),
        .DebounceCycles(DebounceCycles)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .btn_rst_i   (btn),
        .pll_locked_i(lock),
        .sw_rst_req_i(sw),
        .rst_no      (rst_out),
        .state_o     (state),
        .rst_cause_o (cause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rst(input logic val, input int budget, input int ref_cyc, output int diff);
        diff = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (rst_out === val) begin
                diff = cyc - ref_cyc;
                break;
            end
        end
    endtask

    task automatic push_exp(input string name, input int edges, input logic [1:0] c);
        exp_t e;
        e.name  = name;
        e.edges = edges;
        e.cause = c & CauseMask;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        lock  = 1'b1;
        step(3);
        checks++; if (rst_out !== 1'b0) begin errors++; $display("FAIL reset_rst: got %b expected 0", rst_out); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (cause !== 2'b00) begin errors++; $display("FAIL reset_cause: got %b expected 00", cause); end
    endtask

    task automatic test_power_up();
        int ref_cyc, d;
        exp_t e;
        rst_n = 1'b1;
        ref_cyc = cyc;
        push_exp("por_release", PorCycles + LockCycles, CAUSE_POR);
        wait_rst(1'b1, 1200, ref_cyc, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL %s_state: got %0d expected 2", e.name, state); end
    endtask

    task automatic test_sw_in_run();
        int ref_cyc, d;
        exp_t e;
        sw = 1'b1;
        ref_cyc = cyc;
        push_exp("sw_run", 1, CAUSE_SW);
        step(1);
        sw = 1'b0;
        if (rst_out === 1'b0) d = cyc - ref_cyc;
        else wait_rst(1'b0, 10, ref_cyc, d);
        e = sb.pop_front();
        last_fall = cyc;
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL %s_state: got %0d expected 0", e.name, state); end
    endtask

    task automatic test_reset_mid_por();
        int ref_cyc, d;
        exp_t e;
        step(499 - (cyc - last_fall));
        rst_n = 1'b0;
        step(1);
        checks++; if (rst_out !== 1'b0) begin errors++; $display("FAIL midpor_rst: got %b expected 0", rst_out); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL midpor_state: got %0d expected 0", state); end
        checks++; if (cause !== 2'b00) begin errors++; $display("FAIL midpor_cause: got %b expected 00", cause); end
        rst_n = 1'b1;
        ref_cyc = cyc;
        push_exp("midpor_release", PorCycles + LockCycles, CAUSE_POR);
        wait_rst(1'b1, 1200, ref_cyc, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
    endtask

    task automatic test_button();
        int ref_cyc, d, drops;
        exp_t e;
        btn = 1'b1;
        step(10);
        btn = 1'b0;
        drops = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (rst_out !== 1'b1) drops++;
        end
        checks++; if (drops !== 0) begin errors++; $display("FAIL btn_glitch: got %0d low cycles expected 0", drops); end
        btn = 1'b1;
        ref_cyc = cyc;
        push_exp("btn_press", DebounceCycles + 3, CAUSE_BUTTON);
        wait_rst(1'b0, 40, ref_cyc, d);
        last_fall = cyc;
        step(1);
        btn = 1'b0;
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL %s_state: got %0d expected 0", e.name, state); end
    endtask

    task automatic test_sw_in_por();
        int d;
        exp_t e;
        step(500 - (cyc - last_fall));
        sw = 1'b1;
        step(1);
        sw = 1'b0;
        checks++; if (state !== 2'd0 || rst_out !== 1'b0) begin errors++; $display("FAIL sw_por_ignored: got state %0d rst %b expected 0 0", state, rst_out); end
        push_exp("btn_recover", PorCycles + LockCycles, CAUSE_BUTTON);
        wait_rst(1'b1, 1200, last_fall, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
    endtask

    task automatic test_lock_loss_sw();
        int ref_cyc, d;
        exp_t e;
        lock = 1'b0;
        ref_cyc = cyc;
        step(2);
        sw = 1'b1;
        push_exp("lockloss_vs_sw", 3, CAUSE_LOCK_LOSS);
        wait_rst(1'b0, 10, ref_cyc, d);
        sw = 1'b0;
        last_fall = cyc;
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
    endtask

    task automatic test_lock_wait();
        int ref_cyc, d;
        exp_t e;
        step(1999 - (cyc - last_fall));
        checks++; if (state !== 2'd1 || rst_out !== 1'b0) begin errors++; $display("FAIL lock_wait_hold: got state %0d rst %b expected 1 0", state, rst_out); end
        lock = 1'b1;
        ref_cyc = cyc;
        push_exp("lock_rise", LockCycles + 2, CAUSE_LOCK_LOSS);
        wait_rst(1'b1, 200, ref_cyc, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
    endtask

    task automatic test_lock_retry();
        int ref_cyc, d;
        exp_t e;
        lock = 1'b0;
        ref_cyc = cyc;
        push_exp("lock_drop", 3, CAUSE_LOCK_LOSS);
        wait_rst(1'b0, 10, ref_cyc, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
        step(1100);
        lock = 1'b1;
        step(32);
        checks++; if (state !== 2'd1 || rst_out !== 1'b0) begin errors++; $display("FAIL lock_mid_count: got state %0d rst %b expected 1 0", state, rst_out); end
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        ref_cyc = cyc;
        push_exp("lock_retry", LockCycles + 2, CAUSE_LOCK_LOSS);
        wait_rst(1'b1, 200, ref_cyc, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
    endtask

    task automatic test_lock_final_cycle();
        int ref_cyc, d;
        exp_t e;
        lock = 1'b0;
        ref_cyc = cyc;
        push_exp("lock_drop2", 3, CAUSE_LOCK_LOSS);
        wait_rst(1'b0, 10, ref_cyc, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        step(1100);
        lock = 1'b1;
        ref_cyc = cyc;
        // drop lands on the synchronised lock exactly at the terminal LOCK count
        step(LockCycles - 1);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        push_exp("lock_final", 2 * LockCycles + 2, CAUSE_LOCK_LOSS);
        wait_rst(1'b1, 300, ref_cyc, d);
        e = sb.pop_front();
        checks++; if (d !== e.edges) begin errors++; $display("FAIL %s_edges: got %0d expected %0d", e.name, d, e.edges); end
        checks++; if (cause !== e.cause) begin errors++; $display("FAIL %s_cause: got %b expected %b", e.name, cause, e.cause); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_in_run();
        test_reset_mid_por();
        test_button();
        test_sw_in_por();
        test_lock_loss_sw();
        test_lock_wait();
        test_lock_retry();
        test_lock_final_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
